// File: rtl/mio_cli_st_rst_seq_ctrl.sv
// Staggered reset sequencer: holds all domains in reset for A cycles, then
// releases them one by one S+1 cycles apart. A software request in RUN restarts the sequence.
module mio_cli_st_rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [CNT_W-1:0]       cfg_assert_cycles,
    input  logic [CNT_W-1:0]       cfg_stagger_cycles,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    output logic                   clk_en_o,
    output logic [NUM_DOMAINS-1:0] rst_n_o,
    output logic                   ready
);

    localparam int IDX_W = $clog2(NUM_DOMAINS);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [1:0]             r_sync;
    state_t                 r_state, w_state;
    logic [CNT_W-1:0]       r_cnt, w_cnt;
    logic [CNT_W-1:0]       r_assert_lat, w_assert_lat;
    logic [CNT_W-1:0]       r_stagger_lat, w_stagger_lat;
    logic [IDX_W-1:0]       r_idx, w_idx;
    logic [NUM_DOMAINS-1:0] r_rst_n, w_rst_n;
    logic                   r_ready, w_ready;
    logic                   r_ack, w_ack;
    logic                   r_clk_en, w_clk_en;
    logic                   w_entry;
    logic [CNT_W-1:0]       w_a_eff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_ASSERT;
            r_cnt         <= '0;
            r_assert_lat  <= '0;
            r_stagger_lat <= '0;
            r_idx         <= '0;
            r_rst_n       <= '0;
            r_ready       <= 1'b0;
            r_ack         <= 1'b0;
            r_clk_en      <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_assert_lat  <= w_assert_lat;
            r_stagger_lat <= w_stagger_lat;
            r_idx         <= w_idx;
            r_rst_n       <= w_rst_n;
            r_ready       <= w_ready;
            r_ack         <= w_ack;
            r_clk_en      <= w_clk_en;
        end
    end

    assign w_a_eff = (r_assert_lat == '0) ? CNT_W'(1) : r_assert_lat;

    // Entry edge is the one where the synchronizer output rises, or an accepted
    // software request; counters count up so the max config value never wraps.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_assert_lat  = r_assert_lat;
        w_stagger_lat = r_stagger_lat;
        w_idx         = r_idx;
        w_rst_n       = r_rst_n;
        w_ready       = r_ready;
        w_ack         = 1'b0;
        w_clk_en      = r_clk_en;
        w_entry       = 1'b0;

        if (!r_sync[1]) begin
            if (r_sync[0]) begin
                w_entry = 1'b1;
            end else begin
                w_state       = ST_ASSERT;
                w_cnt         = '0;
                w_assert_lat  = '0;
                w_stagger_lat = '0;
                w_idx         = '0;
                w_rst_n       = '0;
                w_ready       = 1'b0;
                w_clk_en      = 1'b0;
            end
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt >= w_a_eff) begin
                        w_state = ST_RELEASE;
                        w_rst_n = NUM_DOMAINS'(1);
                        w_idx   = IDX_W'(1);
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == r_stagger_lat) begin
                        w_rst_n = r_rst_n | (NUM_DOMAINS'(1) << r_idx);
                        w_cnt   = '0;
                        if (r_idx == IDX_W'(NUM_DOMAINS - 1)) begin
                            w_state = ST_RUN;
                            w_ready = 1'b1;
                        end else begin
                            w_idx = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_rst_req) begin
                        w_entry = 1'b1;
                        w_ack   = 1'b1;
                    end
                end
                default: begin
                    w_entry = 1'b1;
                end
            endcase
        end

        if (w_entry) begin
            w_state       = ST_ASSERT;
            w_cnt         = CNT_W'(1);
            w_assert_lat  = cfg_assert_cycles;
            w_stagger_lat = cfg_stagger_cycles;
            w_idx         = '0;
            w_rst_n       = '0;
            w_ready       = 1'b0;
            w_clk_en      = 1'b1;
        end
    end

    assign sw_rst_ack = r_ack;
    assign clk_en_o   = r_clk_en;
    assign rst_n_o    = r_rst_n;
    assign ready      = r_ready;

endmodule

// File: tb/tb_mio_cli_st_rst_seq_ctrl.sv
// Self-checking bench for mio_cli_st_rst_seq_ctrl: expected release times are
// computed directly as E + A + i*(S+1) per domain.
module tb_mio_cli_st_rst_seq_ctrl;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk     = 1'b0;
    logic         clkRun  = 1'b1;
    logic         reset_n = 1'b1;
    logic [W-1:0] cfgA    = '0;
    logic [W-1:0] cfgS    = '0;
    logic         req     = 1'b0;
    logic         ack;
    logic         clkEn;
    logic [N-1:0] rstN;
    logic         rdy;

    int checks = 0;
    int errors = 0;

    mio_cli_st_rst_seq_ctrl #(.NUM_DOMAINS(N), .CNT_W(W)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cfg_assert_cycles  (cfgA),
        .cfg_stagger_cycles (cfgS),
        .sw_rst_req         (req),
        .sw_rst_ack         (ack),
        .clk_en_o           (clkEn),
        .rst_n_o            (rstN),
        .ready              (rdy)
    );

    always begin
        #5;
        if (clkRun) clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] expRst(input int k, input int aEff, input int s);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (k >= aEff + i * (s + 1)) v[i] = 1'b1;
        return v;
    endfunction

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_rst"},   32'(rstN),  32'h0);
        checkOutput({tag, "_clken"}, 32'(clkEn), 32'h0);
        checkOutput({tag, "_ready"}, 32'(rdy),   32'h0);
        checkOutput({tag, "_ack"},   32'(ack),   32'h0);
    endtask

    // Leaves the bench at the falling edge just after the ASSERT entry edge E.
    task automatic doReset(input int a, input int s);
        req     = 1'b0;
        cfgA    = W'(a);
        cfgS    = W'(s);
        reset_n = 1'b0;
        #1;
        checkAllLow("rstAsync");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllLow("rstHeld");
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllLow("rstSync1");
        @(posedge clk);
        @(negedge clk);
    endtask

    // Walks one sequence from k = 0 (just after E); stops early at stopAt if >= 0.
    task automatic checkSeq(input int a, input int s, input bit expAck,
                            input bit disturb, input bit hold, input int stopAt);
        int aEff;
        int tLast;
        int kEnd;
        aEff  = (a == 0) ? 1 : a;
        tLast = aEff + (N - 1) * (s + 1);
        kEnd  = hold ? tLast : tLast + 2;
        for (int k = 0; k <= kEnd; k++) begin
            checkOutput("rst_n_o",  32'(rstN),  32'(expRst(k, aEff, s)));
            checkOutput("ready",    32'(rdy),   32'(k >= tLast));
            checkOutput("clk_en_o", 32'(clkEn), 32'h1);
            checkOutput("ack",      32'(ack),   32'(expAck && k == 0));
            if (k == stopAt) return;
            if (k < kEnd) begin
                if (disturb && k < tLast) begin
                    req = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) cfgA = W'(9);
                    if ($urandom_range(0, 3) == 0) cfgS = W'($urandom_range(0, 255));
                end else begin
                    req = hold;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic applyStimulus(input int a, input int s, input bit disturb, input bit hold);
        cfgA = W'(a);
        cfgS = W'(s);
        req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = hold;
        checkSeq(a, s, 1'b1, disturb, hold, -1);
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            req = 1'b0;
            checkSeq(a, s, 1'b1, 1'b0, 1'b0, -1);
        end
    endtask

    initial begin
        #1;
        doReset(4, 2);
        checkSeq(4, 2, 1'b0, 1'b0, 1'b0, -1);

        applyStimulus(4, 2, 1'b0, 1'b0);
        applyStimulus(4, 2, 1'b1, 1'b0);

        doReset(0, 0);
        checkSeq(0, 0, 1'b0, 1'b0, 1'b0, -1);

        applyStimulus(2, 1, 1'b0, 1'b1);

        for (int it = 0; it < 8; it++) begin
            applyStimulus($urandom_range(0, 6), $urandom_range(0, 5),
                          1'($urandom_range(0, 1)), 1'b0);
        end

        doReset(4, 2);
        checkSeq(4, 2, 1'b0, 1'b0, 1'b0, 8);
        clkRun = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkAllLow("midSeqRst");
        #20;
        checkAllLow("midSeqStopped");
        clkRun = 1'b1;
        doReset(4, 2);
        checkSeq(4, 2, 1'b0, 1'b0, 1'b0, -1);

        doReset(255, 255);
        checkSeq(255, 255, 1'b0, 1'b0, 1'b0, -1);
        applyStimulus(3, 0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
